// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S frame constants and the synthesizer's stereo word packing
package i2s_pkg;

    localparam int FRAME_BITS    = 64;
    localparam int SLOT_BITS     = 32;
    localparam int SAMPLE_BITS   = 16;
    localparam int LEFT_MSB_POS  = 1;
    localparam int RIGHT_MSB_POS = LEFT_MSB_POS + SLOT_BITS;
    localparam int POS_W         = $clog2(FRAME_BITS);

    // Synthesizer output word: {right[31:16], left[15:0]}
    typedef struct packed {
        logic [15:0] right;
        logic [15:0] left;
    } stereo_word_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// rtl/i2s_bclk_gen.sv - bit clock: falls on each strobe, rises TICK_HALF clks later
module i2s_bclk_gen #(
    parameter int TICK_HALF = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_strobe,
    output logic o_bclk
);

    localparam int CNT_W = (TICK_HALF > 1) ? $clog2(TICK_HALF) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_run;
    logic             r_bclk;

    // A strobe always wins: it restarts the half period even if the previous one is unfinished.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_bclk <= 1'b0;
        end else if (i_strobe) begin
            r_bclk <= 1'b0;
            r_cnt  <= CNT_W'(TICK_HALF - 1);
            r_run  <= 1'b1;
        end else if (r_run) begin
            if (r_cnt == '0) begin
                r_bclk <= 1'b1;
                r_run  <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_bclk = r_bclk;

endmodule

// File: rtl/i2s_transmitter.sv
// rtl/i2s_transmitter.sv - Philips I2S serialiser for the 32-bit {right,left} synthesizer word
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int TICK_HALF   = 16,
    parameter int SAMPLE_BITS = i2s_pkg::SAMPLE_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena_sampleRatex64,
    input  logic [31:0] data,
    input  logic        i2s_ena,
    output logic        i2s_bclk,
    output logic        i2s_lrck,
    output logic        i2s_sdata,
    output logic        frame_start,
    output logic        active
);

    localparam int LEFT_LAST  = LEFT_MSB_POS + SAMPLE_BITS - 1;
    localparam int RIGHT_LAST = RIGHT_MSB_POS + SAMPLE_BITS - 1;
    localparam int IDX_W      = $clog2(SAMPLE_BITS);

    logic [POS_W-1:0] r_pos;
    logic             r_lrck;
    logic             r_sdata;
    logic             r_frame_start;
    logic             r_active;
    stereo_word_t     r_word;

    logic [POS_W-1:0] w_new_pos;
    logic             w_bit;
    int               w_p;

    i2s_bclk_gen #(
        .TICK_HALF (TICK_HALF)
    ) u_bclk_gen (
        .clk      (clk),
        .rst      (rst),
        .i_strobe (ena_sampleRatex64),
        .o_bclk   (i2s_bclk)
    );

    assign w_new_pos = r_pos + 1'b1;

    // Data lags the LRCK edge by one bit; the rest of each slot is zero padding.
    always_comb begin
        w_bit = 1'b0;
        w_p   = int'(w_new_pos);
        if (w_p >= LEFT_MSB_POS && w_p <= LEFT_LAST) begin
            w_bit = r_word.left[IDX_W'(LEFT_LAST - w_p)];
        end else if (w_p >= RIGHT_MSB_POS && w_p <= RIGHT_LAST) begin
            w_bit = r_word.right[IDX_W'(RIGHT_LAST - w_p)];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos         <= '1;
            r_lrck        <= 1'b0;
            r_sdata       <= 1'b0;
            r_frame_start <= 1'b0;
            r_active      <= 1'b0;
            r_word        <= '0;
        end else begin
            r_frame_start <= 1'b0;
            if (ena_sampleRatex64) begin
                r_pos   <= w_new_pos;
                r_lrck  <= w_new_pos[POS_W-1];
                r_sdata <= w_bit;
                if (w_new_pos == '0) begin
                    r_frame_start <= 1'b1;
                    r_active      <= i2s_ena;
                    r_word        <= i2s_ena ? stereo_word_t'(data) : '0;
                end
            end
        end
    end

    assign i2s_lrck    = r_lrck;
    assign i2s_sdata   = r_sdata;
    assign frame_start = r_frame_start;
    assign active      = r_active;

endmodule

// File: tb/tb_i2s_transmitter.sv
// tb/tb_i2s_transmitter.sv - scoreboard bench for i2s_transmitter against a frame-level model
module tb_i2s_transmitter;

    localparam int TICK_HALF = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena_sampleRatex64 = 1'b0;
    logic [31:0] data = '0;
    logic        i2s_ena = 1'b0;
    logic        i2s_bclk, i2s_lrck, i2s_sdata, frame_start, active;

    always #5 clk = ~clk;

    i2s_transmitter #(.TICK_HALF(TICK_HALF), .SAMPLE_BITS(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .ena_sampleRatex64 (ena_sampleRatex64),
        .data              (data),
        .i2s_ena           (i2s_ena),
        .i2s_bclk          (i2s_bclk),
        .i2s_lrck          (i2s_lrck),
        .i2s_sdata         (i2s_sdata),
        .frame_start       (frame_start),
        .active            (active)
    );

    typedef struct {
        bit lrck;
        bit sdata;
        bit fs;
        bit act;
        int pos;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   fs_seen  = 0;

    logic        p_rst = 1'b1;
    logic        p_ena = 1'b0;
    logic [31:0] p_data = '0;

    int          mpos  = 63;
    logic [31:0] mword = '0;
    bit          mact  = 1'b0;

    task automatic chk(input string name, input logic got, input logic want, input int pos);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (pos %0d, t=%0t)", name, got, want, pos, $time);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Each slot is 32 bits: one idle bit, 16 sample bits MSB-first, then zeros.
    function automatic bit ref_bit(input logic [31:0] w, input int p);
        int          slot;
        int          off;
        logic [15:0] sample;
        slot   = p / 32;
        off    = p % 32;
        sample = (slot == 0) ? w[15:0] : w[31:16];
        if (off >= 1 && off <= 16) return sample[16 - off];
        return 1'b0;
    endfunction

    task automatic step(input bit strobe);
        exp_t e;
        @(negedge clk);
        rst               = p_rst;
        i2s_ena           = p_ena;
        data              = p_data;
        ena_sampleRatex64 = strobe;
        @(posedge clk);
        if (rst) begin
            mpos  = 63;
            mword = '0;
            mact  = 1'b0;
        end else if (strobe) begin
            mpos = (mpos + 1) % 64;
            if (mpos == 0) begin
                mword = i2s_ena ? data : 32'h0;
                mact  = i2s_ena;
            end
            e.lrck  = (mpos >= 32);
            e.sdata = ref_bit(mword, mpos);
            e.fs    = (mpos == 0);
            e.act   = mact;
            e.pos   = mpos;
            expq.push_back(e);
        end
    endtask

    task automatic bit_period(input int period);
        step(1'b1);
        repeat (period - 1) step(1'b0);
    endtask

    // Monitor: reloads expectations after every accepted strobe, holds them otherwise.
    initial begin
        exp_t cur;
        bit   s, r;
        bit   seen;
        int   since;
        cur   = '{lrck: 0, sdata: 0, fs: 0, act: 0, pos: 63};
        seen  = 1'b0;
        since = 0;
        forever begin
            @(posedge clk);
            s = ena_sampleRatex64;
            r = rst;
            @(negedge clk);
            if (r) begin
                cur   = '{lrck: 0, sdata: 0, fs: 0, act: 0, pos: 63};
                seen  = 1'b0;
                since = 0;
            end else if (s) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: strobe with no expected entry at t=%0t", $time);
                end else begin
                    cur = expq.pop_front();
                end
                seen  = 1'b1;
                since = 0;
            end else if (seen) begin
                since++;
            end
            if (frame_start === 1'b1) fs_seen++;
            chk("lrck", i2s_lrck, cur.lrck, cur.pos);
            chk("sdata", i2s_sdata, cur.sdata, cur.pos);
            chk("frame_start", frame_start, s && !r && cur.fs, cur.pos);
            chk("active", active, cur.act, cur.pos);
            chk("bclk", i2s_bclk, seen && since >= TICK_HALF, cur.pos);
        end
    end

    initial begin
        int fs_base;
        int hook;
        int per;

        // T1: reset with strobes present
        p_rst = 1'b1;
        repeat (3) step(1'b1);
        p_rst = 1'b0;
        repeat (4) step(1'b0);

        // T2/T3: one frame of a known word at 32-clk bit periods
        fs_base = fs_seen;
        p_ena   = 1'b1;
        p_data  = 32'hA5A5_8001;
        repeat (64) bit_period(32);
        chk_int("t2_frame_start_count", fs_seen - fs_base, 1);

        // T4: drop enable at pos 20, then an all-zero frame
        p_data = 32'h1234_F00D;
        for (int i = 0; i < 64; i++) begin
            step(1'b1);
            if (mpos == 20) p_ena = 1'b0;
            repeat (31) step(1'b0);
        end
        repeat (64) bit_period(32);

        // T5: data change at pos 5 lands in the next frame
        p_ena  = 1'b1;
        p_data = 32'h5A3C_C3A5;
        for (int i = 0; i < 64; i++) begin
            step(1'b1);
            if (mpos == 5) p_data = 32'h0000_FFFF;
            repeat (31) step(1'b0);
        end
        repeat (64) bit_period(32);

        // T6: reset at pos 40, then a fresh frame
        p_data = 32'h8000_7FFF;
        for (int i = 0; i < 41; i++) bit_period(32);
        p_rst = 1'b1;
        repeat (3) step(1'b1);
        p_rst   = 1'b0;
        fs_base = fs_seen;
        repeat (64) bit_period(32);
        chk_int("t6_frame_start_after_reset", fs_seen - fs_base, 1);

        // Random frames: random word/enable, mid-frame changes, some short periods that restart BCLK
        for (int f = 0; f < 6; f++) begin
            hook = int'($urandom_range(0, 63));
            for (int i = 0; i < 64; i++) begin
                per = ($urandom_range(0, 15) == 0) ? int'($urandom_range(3, 15))
                                                   : int'($urandom_range(17, 36));
                step(1'b1);
                if (mpos == hook) begin
                    p_data = $urandom;
                    p_ena  = ($urandom_range(0, 3) != 0);
                end
                repeat (per - 1) step(1'b0);
            end
        end

        repeat (4) step(1'b0);
        chk_int("scoreboard_drained", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
